if_pc_unit: RTL and testbench
=============================

# if_pc_unit

Instruction-fetch program-counter unit for the MIPS pipeline. It is the consuming end of the execute-stage branch-target adder: it accepts the taken-branch target from EXE and redirects fetch to it. It also holds and advances the PC, issues requests to instruction memory with a ready handshake, and reports the fetched PC to the IF/ID register. It flags wrong-path slots and misaligned targets, and counts redirects.

## Interface
- RESET_PC, 32'h0040_0000, PC fetched first after reset
- CNT_W, 16, width of redirect counter
- clk  in  1  pipeline clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- stall  in  1  hazard-unit freeze; holds the PC and suppresses new requests
- branch_taken  in  1  EXE resolved a taken branch this cycle
- branch_target  in  32  target from the EXE branch adder; sampled when branch_taken=1
- imem_ready  in  1  instruction memory accepts a request this cycle
- imem_req  out  1  fetch request valid
- imem_addr  out  32  fetch address (current fetch PC)
- pc_out  out  32  PC of the instruction accepted last cycle (to IF/ID)
- pc_plus4  out  32  pc_out + 4 (to IF/ID, for link/next-PC)
- if_valid  out  1  pc_out/pc_plus4 describe a valid correct-path fetch
- if_flush  out  1  one-cycle pulse: kill IF/ID contents (wrong path)
- addr_misaligned  out  1  sticky: a taken target had bits [1:0] != 0
- redirect_count  out  CNT_W  saturating count of accepted redirects

## Operation
- States: BOOT, RUN, REDIRECT, HALT.
- BOOT: entered on rst. imem_req=0. Goes to RUN after one cycle.
- RUN/REDIRECT: imem_req = !stall, imem_addr = fetch_pc. accept = imem_req & imem_ready.
- On accept (no branch): fetch_pc <= fetch_pc+4, pc_out <= fetch_pc, pc_plus4 <= fetch_pc+4, if_valid <= 1. Otherwise if_valid <= 0 and fetch_pc holds.
- REDIRECT goes to RUN on first accept. Otherwise it behaves like RUN, and only exists to mark the post-redirect slot.
- Priority per cycle: rst > branch_taken > stall > normal advance.
- branch_taken with branch_target[1:0]==0, from RUN or REDIRECT:
  - fetch_pc <= branch_target; state <= REDIRECT.
  - if_valid <= 0, because any accept in that cycle is wrong path and is discarded.
  - if_flush <= 1; redirect_count increments, saturating at all-ones.
- branch_taken with a misaligned target: state <= HALT, addr_misaligned <= 1, if_flush <= 1. redirect_count is unchanged.
- HALT: imem_req=0 and if_valid=0. All inputs are ignored until rst.
- branch_taken in BOOT is ignored.
- stall does not block a redirect: the target is loaded, and the request is issued once stall drops.
- Arithmetic: all PC math is unsigned mod 2^32; 32'hFFFF_FFFC + 4 = 32'h0000_0000 with no flag.

## Timing
- Reset values:
  - state=BOOT, fetch_pc=RESET_PC
  - pc_out=RESET_PC, pc_plus4=RESET_PC+4
  - imem_req=0, if_valid=0, if_flush=0, addr_misaligned=0, redirect_count=0
- First request: the second cycle after rst deasserts (cycle 1 is BOOT).
- Latency from accept to if_valid/pc_out: exactly 1 cycle.
- Latency from branch_taken to imem_addr=target: 1 cycle.
- if_flush is high exactly 1 cycle, in the cycle after branch_taken.
- Back-to-back accepts sustain 1 fetch per cycle.
- imem_ready low: imem_addr is stable and if_valid=0 every cycle until accept.
- Branch in consecutive cycles: the later target wins; if_flush stays high both cycles; the counter increments twice.
- rst mid-redirect or in HALT: full reset values on the next edge. There is no pending state.
- imem_req and imem_addr are combinational from registered state only. There is no input-to-output combinational path except stall→imem_req.

## Structure
- Shared package mips_pkg holds:
  - the if_state_t enum (BOOT, RUN, REDIRECT, HALT)
  - INSTR_BYTES=4
  - the default RESET_PC constant
- One natural sub-module: pc_incrementer, a 32-bit +4 adder that is combinational and wraps. It is instantiated once for fetch_pc+4; pc_plus4 is registered from that same instance's output at accept.
- Redirect counter and state register are inline.

## Test plan
- Reset: rst=1 for 2 cycles, RESET_PC=0x0040_0000 → all outputs at reset values. After release: cycle 1 imem_req=0; cycle 2 imem_req=1, imem_addr=0x0040_0000.
- Streaming: imem_ready=1 → if_valid=1 with pc_out 0x0040_0000, 0x0040_0004, 0x0040_0008 and pc_plus4 0x0040_0004, 0x0040_0008, 0x0040_000C on consecutive cycles.
- Memory backpressure: imem_ready=0 for 3 cycles at 0x0040_0008 → imem_addr held, if_valid=0 for 3 cycles, then resumes at 0x0040_0008. Repeat with stall=1 for 2 cycles → imem_req=0 and no advance.
- Redirect: branch_taken=1, target 0x0040_0040 while accepting 0x0040_000C → next cycle if_flush=1, if_valid=0, imem_addr=0x0040_0040, redirect_count=1. The following cycle: pc_out=0x0040_0040, if_valid=1.
- Misaligned: target 0x0040_0042 → addr_misaligned=1, if_flush pulse, imem_req=0 for 10+ cycles, counter unchanged; cleared only by rst.
- Corner cases:
  - branch_taken and stall together → redirect still loads the target.
  - fetch_pc 0xFFFF_FFFC accepted → next imem_addr=0x0000_0000, pc_plus4=0x0000_0000.
  - 2^CNT_W+2 redirects → counter saturates at all-ones.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: fetch-unit state encoding and fetch constants.
package mips_pkg;
  typedef enum logic [1:0] {BOOT, RUN, REDIRECT, HALT} if_state_t;
  localparam int          INSTR_BYTES      = 4;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0040_0000;
endpackage

// File: rtl/pc_incrementer.sv
// Combinational next-sequential-PC adder; wraps modulo 2^32 with no carry out.
module pc_incrementer
  import mips_pkg::*;
(
  input  logic [31:0] a_i,
  output logic [31:0] sum_o
);
  assign sum_o = a_i + 32'(INSTR_BYTES);
endmodule

// File: rtl/if_pc_unit.sv
// Instruction-fetch PC unit: holds/advances fetch PC, handshakes with imem,
// redirects on taken EXE branches, and reports the accepted PC to IF/ID.
module if_pc_unit
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int          CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             branch_taken,
  input  logic [31:0]      branch_target,
  input  logic             imem_ready,
  output logic             imem_req,
  output logic [31:0]      imem_addr,
  output logic [31:0]      pc_out,
  output logic [31:0]      pc_plus4,
  output logic             if_valid,
  output logic             if_flush,
  output logic             addr_misaligned,
  output logic [CNT_W-1:0] redirect_count
);
  localparam logic [31:0] RESET_PC_P4 = RESET_PC + 32'(INSTR_BYTES);

  if_state_t        state_q, state_d;
  logic [31:0]      fetch_pc_q, fetch_pc_d;
  logic [31:0]      pc_out_q, pc_out_d;
  logic [31:0]      pc_plus4_q, pc_plus4_d;
  logic             if_valid_q, if_valid_d;
  logic             if_flush_q, if_flush_d;
  logic             misaligned_q, misaligned_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      fetch_pc_inc;
  logic             fetching, accept;

  pc_incrementer u_inc (
    .a_i   (fetch_pc_q),
    .sum_o (fetch_pc_inc)
  );

  // Request depends only on registered state plus the live stall input.
  assign fetching = (state_q == RUN) || (state_q == REDIRECT);
  assign imem_req = fetching && !stall;
  assign accept   = imem_req && imem_ready;

  always_comb begin
    state_d      = state_q;
    fetch_pc_d   = fetch_pc_q;
    pc_out_d     = pc_out_q;
    pc_plus4_d   = pc_plus4_q;
    if_valid_d   = 1'b0;
    if_flush_d   = 1'b0;
    misaligned_d = misaligned_q;
    cnt_d        = cnt_q;
    unique case (state_q)
      BOOT: state_d = RUN;
      RUN, REDIRECT: begin
        if (branch_taken) begin
          // Whatever is accepted this cycle is wrong-path and gets dropped.
          if_flush_d = 1'b1;
          if (branch_target[1:0] == 2'b00) begin
            fetch_pc_d = branch_target;
            state_d    = REDIRECT;
            if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + CNT_W'(1);
          end else begin
            state_d      = HALT;
            misaligned_d = 1'b1;
          end
        end else if (accept) begin
          fetch_pc_d = fetch_pc_inc;
          pc_out_d   = fetch_pc_q;
          pc_plus4_d = fetch_pc_inc;
          if_valid_d = 1'b1;
          state_d    = RUN;
        end
      end
      HALT: state_d = HALT;
      default: state_d = BOOT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= BOOT;
      fetch_pc_q   <= RESET_PC;
      pc_out_q     <= RESET_PC;
      pc_plus4_q   <= RESET_PC_P4;
      if_valid_q   <= 1'b0;
      if_flush_q   <= 1'b0;
      misaligned_q <= 1'b0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      fetch_pc_q   <= fetch_pc_d;
      pc_out_q     <= pc_out_d;
      pc_plus4_q   <= pc_plus4_d;
      if_valid_q   <= if_valid_d;
      if_flush_q   <= if_flush_d;
      misaligned_q <= misaligned_d;
      cnt_q        <= cnt_d;
    end
  end

  assign imem_addr       = fetch_pc_q;
  assign pc_out          = pc_out_q;
  assign pc_plus4        = pc_plus4_q;
  assign if_valid        = if_valid_q;
  assign if_flush        = if_flush_q;
  assign addr_misaligned = misaligned_q;
  assign redirect_count  = cnt_q;
endmodule

// File: tb/tb_if_pc_unit.sv
// Bench for if_pc_unit: behavioural fetch model checked every cycle, directed
// literal checks, randomized traffic, and counter saturation.
module tb_if_pc_unit;
  localparam logic [31:0] RPC   = 32'h0040_0000;
  localparam int          CNT_W = 16;
  localparam int          MAXC  = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1, stall = 1'b0, branch_taken = 1'b0, imem_ready = 1'b0;
  logic [31:0] branch_target = '0;
  logic imem_req, if_valid, if_flush, addr_misaligned;
  logic [31:0] imem_addr, pc_out, pc_plus4;
  logic [CNT_W-1:0] redirect_count;

  int n_chk = 0, n_fail = 0;
  bit started = 1'b0;

  if_pc_unit #(.RESET_PC(RPC), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .stall(stall), .branch_taken(branch_taken),
    .branch_target(branch_target), .imem_ready(imem_ready),
    .imem_req(imem_req), .imem_addr(imem_addr), .pc_out(pc_out),
    .pc_plus4(pc_plus4), .if_valid(if_valid), .if_flush(if_flush),
    .addr_misaligned(addr_misaligned), .redirect_count(redirect_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail < 40) $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: mode 0=booting, 1=fetching, 2=halted. The post-redirect
  // marker is unobservable, so the model does not track it.
  int          m_mode = 0;
  logic [31:0] m_pc = RPC, m_out = RPC, m_p4 = RPC + 32'd4;
  bit          m_val = 0, m_flush = 0, m_mis = 0;
  int          m_cnt = 0;

  always @(posedge clk) begin
    started <= 1'b1;
    if (rst) begin
      m_mode <= 0; m_pc <= RPC; m_out <= RPC; m_p4 <= RPC + 32'd4;
      m_val <= 0; m_flush <= 0; m_mis <= 0; m_cnt <= 0;
    end else if (m_mode == 0) begin
      m_mode <= 1; m_val <= 0; m_flush <= 0;
    end else if (m_mode == 2) begin
      m_val <= 0; m_flush <= 0;
    end else if (branch_taken) begin
      m_val <= 0; m_flush <= 1;
      if (branch_target % 4 == 0) begin
        m_pc  <= branch_target;
        m_cnt <= (m_cnt >= MAXC) ? MAXC : m_cnt + 1;
      end else begin
        m_mode <= 2; m_mis <= 1;
      end
    end else begin
      m_flush <= 0;
      if (!stall && imem_ready) begin
        m_out <= m_pc; m_p4 <= m_pc + 32'd4; m_pc <= m_pc + 32'd4; m_val <= 1;
      end else m_val <= 0;
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("imem_req", 32'(imem_req), 32'(m_mode == 1 && !stall));
      chk("imem_addr", imem_addr, m_pc);
      chk("pc_out", pc_out, m_out);
      chk("pc_plus4", pc_plus4, m_p4);
      chk("if_valid", 32'(if_valid), 32'(m_val));
      chk("if_flush", 32'(if_flush), 32'(m_flush));
      chk("addr_misaligned", 32'(addr_misaligned), 32'(m_mis));
      chk("redirect_count", 32'(redirect_count), 32'(m_cnt));
    end
  end

  task automatic step(input logic r, input logic s, input logic rdy,
                      input logic b, input logic [31:0] t);
    rst = r; stall = s; imem_ready = rdy; branch_taken = b; branch_target = t;
    @(posedge clk); #1;
  endtask

  initial begin
    step(1, 0, 1, 0, 0);
    step(1, 0, 1, 0, 0);
    chk("rst_pc_out", pc_out, RPC);
    chk("rst_pc_plus4", pc_plus4, 32'h0040_0004);
    chk("rst_addr", imem_addr, RPC);
    chk("rst_flags", {28'd0, imem_req, if_valid, if_flush, addr_misaligned}, 32'd0);
    chk("rst_cnt", 32'(redirect_count), 32'd0);
    rst = 1'b0; #1;
    chk("boot_req", 32'(imem_req), 32'd0);
    step(0, 0, 1, 0, 0);
    chk("first_req", 32'(imem_req), 32'd1);
    chk("first_addr", imem_addr, 32'h0040_0000);
    step(0, 0, 1, 0, 0);
    chk("s0_pc", pc_out, 32'h0040_0000); chk("s0_p4", pc_plus4, 32'h0040_0004);
    chk("s0_v", 32'(if_valid), 32'd1);
    step(0, 0, 1, 0, 0);
    chk("s1_pc", pc_out, 32'h0040_0004); chk("s1_p4", pc_plus4, 32'h0040_0008);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 0, 0);
      chk("bp_addr", imem_addr, 32'h0040_0008); chk("bp_v", 32'(if_valid), 32'd0);
    end
    step(0, 0, 1, 0, 0);
    chk("s2_pc", pc_out, 32'h0040_0008); chk("s2_p4", pc_plus4, 32'h0040_000C);
    for (int i = 0; i < 2; i++) begin
      step(0, 1, 1, 0, 0);
      chk("stall_req", 32'(imem_req), 32'd0); chk("stall_addr", imem_addr, 32'h0040_000C);
      chk("stall_v", 32'(if_valid), 32'd0);
    end
    step(0, 0, 1, 1, 32'h0040_0040);
    chk("br_flush", 32'(if_flush), 32'd1); chk("br_v", 32'(if_valid), 32'd0);
    chk("br_addr", imem_addr, 32'h0040_0040); chk("br_cnt", 32'(redirect_count), 32'd1);
    step(0, 0, 1, 0, 0);
    chk("br_pc", pc_out, 32'h0040_0040); chk("br_v2", 32'(if_valid), 32'd1);
    chk("br_flush2", 32'(if_flush), 32'd0);
    step(0, 1, 1, 1, 32'h0040_0080);
    chk("bs_addr", imem_addr, 32'h0040_0080); chk("bs_cnt", 32'(redirect_count), 32'd2);
    step(0, 1, 1, 0, 0);
    chk("bs_hold", imem_addr, 32'h0040_0080);
    step(0, 0, 1, 0, 0);
    chk("bs_pc", pc_out, 32'h0040_0080);
    step(0, 0, 1, 1, 32'hFFFF_FFFC);
    step(0, 0, 1, 0, 0);
    chk("wrap_pc", pc_out, 32'hFFFF_FFFC); chk("wrap_p4", pc_plus4, 32'h0000_0000);
    chk("wrap_addr", imem_addr, 32'h0000_0000);
    step(0, 0, 1, 1, 32'h0000_0100);
    step(0, 0, 1, 1, 32'h0000_0200);
    chk("b2_flush", 32'(if_flush), 32'd1); chk("b2_addr", imem_addr, 32'h0000_0200);
    chk("b2_cnt", 32'(redirect_count), 32'd5);
    step(0, 0, 1, 0, 0);
    chk("b2_pc", pc_out, 32'h0000_0200);
    step(0, 0, 1, 1, 32'h0040_0042);
    chk("mis_flag", 32'(addr_misaligned), 32'd1); chk("mis_flush", 32'(if_flush), 32'd1);
    chk("mis_req", 32'(imem_req), 32'd0); chk("mis_cnt", 32'(redirect_count), 32'd5);
    for (int i = 0; i < 11; i++) begin
      step(0, 0, 1, 1'(i % 2), 32'h0000_1000);
      chk("halt_req", 32'(imem_req), 32'd0); chk("halt_mis", 32'(addr_misaligned), 32'd1);
      chk("halt_cnt", 32'(redirect_count), 32'd5);
    end
    step(1, 0, 1, 0, 0);
    chk("clr_mis", 32'(addr_misaligned), 32'd0); chk("clr_cnt", 32'(redirect_count), 32'd0);

    for (int i = 0; i < 4000; i++) begin
      logic [31:0] t;
      logic b;
      t = $urandom;
      b = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 39) != 0) t[1:0] = 2'b00;
      if ($urandom_range(0, 15) == 0) t = 32'hFFFF_FFF8;
      step(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 2) != 0), b, t);
    end

    step(1, 0, 1, 0, 0);
    step(0, 0, 1, 0, 0);
    for (int i = 0; i < (1 << CNT_W) + 2; i++) step(0, 1'($urandom_range(0, 1)), 1, 1, 32'h0000_0400);
    chk("sat_cnt", 32'(redirect_count), 32'h0000_FFFF);
    step(0, 0, 1, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
